// File: rtl/time_query_responder_pkg.sv
// time_query_responder_pkg: shared ASCII constants, command codes, message lengths and types
package time_query_responder_pkg;
  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_DASH  = 8'h2D;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_QMARK = 8'h3F;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] CMD_TIME_DEF = 8'h54;
  localparam logic [7:0] CMD_DATE_DEF = 8'h44;
  localparam logic [7:0] CMD_ALL_DEF  = 8'h41;
  localparam int IDX_W = 5;
  localparam logic [IDX_W-1:0] LEN_TIME = 5'd10;
  localparam logic [IDX_W-1:0] LEN_DATE = 5'd12;
  localparam logic [IDX_W-1:0] LEN_ALL  = 5'd21;
  localparam logic [IDX_W-1:0] LEN_ERR  = 5'd3;
  typedef enum logic {IDLE, SEND} state_t;
  typedef enum logic [1:0] {MSG_TIME, MSG_DATE, MSG_ALL, MSG_ERR} msg_t;
  typedef struct packed {
    logic [15:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  minute;
    logic [7:0]  second;
  } snap_t;
  function automatic logic [7:0] bcd_char(input logic [3:0] n);
    return n > 4'd9 ? ASC_QMARK : ASC_0 + {4'h0, n};
  endfunction
  function automatic logic [IDX_W-1:0] msg_len(input msg_t m);
    return m == MSG_TIME ? LEN_TIME : m == MSG_DATE ? LEN_DATE : m == MSG_ALL ? LEN_ALL : LEN_ERR;
  endfunction
endpackage

// File: rtl/time_char_mux.sv
// time_char_mux: maps message type, byte index and snapshot to the ASCII byte to send
module time_char_mux
  import time_query_responder_pkg::*;
(
  input  msg_t             msg_i,
  input  logic [IDX_W-1:0] idx_i,
  input  snap_t            snap_i,
  output logic [7:0]       char_o
);
  logic [IDX_W-1:0] pos;
  logic [7:0]       full_char;
  // every message is a window into "YYYY-MM-DD hh:mm:ss\r\n"; the date skips the time part before CR/LF
  always_comb begin
    pos = msg_i == MSG_TIME ? idx_i + 5'd11 :
          (msg_i == MSG_DATE && idx_i >= 5'd10) ? idx_i + 5'd9 : idx_i;
    case (pos)
      5'd0:    full_char = bcd_char(snap_i.year[15:12]);
      5'd1:    full_char = bcd_char(snap_i.year[11:8]);
      5'd2:    full_char = bcd_char(snap_i.year[7:4]);
      5'd3:    full_char = bcd_char(snap_i.year[3:0]);
      5'd4:    full_char = ASC_DASH;
      5'd5:    full_char = bcd_char(snap_i.month[7:4]);
      5'd6:    full_char = bcd_char(snap_i.month[3:0]);
      5'd7:    full_char = ASC_DASH;
      5'd8:    full_char = bcd_char(snap_i.day[7:4]);
      5'd9:    full_char = bcd_char(snap_i.day[3:0]);
      5'd10:   full_char = ASC_SPACE;
      5'd11:   full_char = bcd_char(snap_i.hour[7:4]);
      5'd12:   full_char = bcd_char(snap_i.hour[3:0]);
      5'd13:   full_char = ASC_COLON;
      5'd14:   full_char = bcd_char(snap_i.minute[7:4]);
      5'd15:   full_char = bcd_char(snap_i.minute[3:0]);
      5'd16:   full_char = ASC_COLON;
      5'd17:   full_char = bcd_char(snap_i.second[7:4]);
      5'd18:   full_char = bcd_char(snap_i.second[3:0]);
      5'd19:   full_char = ASC_CR;
      5'd20:   full_char = ASC_LF;
      default: full_char = 8'h00;
    endcase
    char_o = msg_i != MSG_ERR ? full_char :
             idx_i == 5'd0 ? ASC_QMARK : idx_i == 5'd1 ? ASC_CR : ASC_LF;
  end
endmodule

// File: rtl/time_query_responder.sv
// time_query_responder: answers UART time/date query bytes with a snapshot of the BCD calendar
module time_query_responder
  import time_query_responder_pkg::*;
#(
  parameter logic [7:0] CMD_TIME = CMD_TIME_DEF,
  parameter logic [7:0] CMD_DATE = CMD_DATE_DEF,
  parameter logic [7:0] CMD_ALL  = CMD_ALL_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [15:0] year_bcd,
  input  logic [7:0]  month_bcd,
  input  logic [7:0]  day_bcd,
  input  logic [7:0]  hour_bcd,
  input  logic [7:0]  minute_bcd,
  input  logic [7:0]  second_bcd,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [7:0]  err_cnt
);
  state_t           state_q, state_d;
  msg_t             msg_q, msg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  snap_t            snap_q, snap_d;
  logic [7:0]       err_q, err_d;
  logic [7:0]       char;
  logic             term, known, hs, last, err_inc;
  time_char_mux u_mux (
    .msg_i  (msg_q),
    .idx_i  (idx_q),
    .snap_i (snap_q),
    .char_o (char)
  );
  // state, index, snapshot and error counter registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      msg_q   <= MSG_TIME;
      idx_q   <= '0;
      snap_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      err_q   <= err_d;
    end
  end
  // next-state: accept commands in IDLE, step through the message on handshakes in SEND
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    term    = rx_data == ASC_CR || rx_data == ASC_LF;
    known   = rx_data == CMD_TIME || rx_data == CMD_DATE || rx_data == CMD_ALL;
    hs      = state_q == SEND && tx_ready;
    last    = idx_q == msg_len(msg_q) - 5'd1;
    err_inc = rx_valid && !term && (state_q == SEND || !known);
    err_d   = err_inc && err_q != 8'hFF ? err_q + 8'd1 : err_q;
    if (state_q == IDLE) begin
      if (rx_valid && !term) begin
        state_d = SEND;
        idx_d   = '0;
        msg_d   = rx_data == CMD_TIME ? MSG_TIME : rx_data == CMD_DATE ? MSG_DATE :
                  rx_data == CMD_ALL ? MSG_ALL : MSG_ERR;
        snap_d  = known ? '{year_bcd, month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd} : snap_q;
      end
    end else if (hs) begin
      state_d = last ? IDLE : SEND;
      idx_d   = last ? '0 : idx_q + 5'd1;
    end
  end
  assign tx_valid = state_q == SEND;
  assign busy     = tx_valid;
  assign tx_data  = tx_valid ? char : 8'h00;
  assign err_cnt  = err_q;
endmodule

// File: tb/tb_time_query_responder.sv
// tb_time_query_responder: directed checks of the time query responder with hand-computed messages
module tb_time_query_responder;
  logic        clk = 0;
  logic        reset_n = 0;
  logic [7:0]  rx_data = 0;
  logic        rx_valid = 0;
  logic [15:0] year_bcd = 16'h2024;
  logic [7:0]  month_bcd = 8'h09, day_bcd = 8'h11, hour_bcd = 8'h21, minute_bcd = 8'h29, second_bcd = 8'h05;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1;
  logic        busy;
  logic [7:0]  err_cnt;
  int vecs = 0, errs = 0;

  time_query_responder dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .year_bcd(year_bcd), .month_bcd(month_bcd), .day_bcd(day_bcd),
    .hour_bcd(hour_bcd), .minute_bcd(minute_bcd), .second_bcd(second_bcd),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    rx_data = c;
    rx_valid = 1;
    tick();
    rx_valid = 0;
  endtask

  task automatic expect_msg(input string tag, input string s, input bit stall, input int inj);
    for (int i = 0; i < s.len(); i++) begin
      if (stall) begin
        tx_ready = 0;
        chk($sformatf("%s stall valid[%0d]", tag, i), {15'd0, tx_valid}, 16'd1);
        chk($sformatf("%s stall data[%0d]", tag, i), {8'd0, tx_data}, {8'd0, s[i]});
        tick();
      end
      tx_ready = 1;
      if (i == inj) begin
        rx_data = 8'h54;
        rx_valid = 1;
        second_bcd = 8'h06;
        day_bcd = 8'h12;
      end
      chk($sformatf("%s valid[%0d]", tag, i), {15'd0, tx_valid}, 16'd1);
      chk($sformatf("%s busy[%0d]", tag, i), {15'd0, busy}, 16'd1);
      chk($sformatf("%s data[%0d]", tag, i), {8'd0, tx_data}, {8'd0, s[i]});
      tick();
      rx_valid = 0;
    end
    chk({tag, " end valid"}, {15'd0, tx_valid}, 16'd0);
    chk({tag, " end busy"}, {15'd0, busy}, 16'd0);
  endtask

  initial begin
    #1;
    do_reset();
    chk("reset valid", {15'd0, tx_valid}, 16'd0);
    chk("reset busy", {15'd0, busy}, 16'd0);
    chk("reset data", {8'd0, tx_data}, 16'h0000);
    chk("reset err", {8'd0, err_cnt}, 16'd0);

    send_cmd(8'h54);
    expect_msg("T", "21:29:05\r\n", 0, -1);
    chk("T err", {8'd0, err_cnt}, 16'd0);

    send_cmd(8'h41);
    expect_msg("A stall", "2024-09-11 21:29:05\r\n", 1, -1);

    send_cmd(8'h44);
    expect_msg("D inject", "2024-09-11\r\n", 0, 5);
    chk("D inject err", {8'd0, err_cnt}, 16'd1);
    second_bcd = 8'h05;
    day_bcd = 8'h11;

    send_cmd(8'h54);
    expect_msg("T last inject", "21:29:05\r\n", 0, 9);
    chk("last inject err", {8'd0, err_cnt}, 16'd2);
    tick();
    chk("last inject no restart", {15'd0, tx_valid}, 16'd0);
    second_bcd = 8'h05;
    day_bcd = 8'h11;

    do_reset();
    send_cmd(8'h78);
    expect_msg("x", "?\r\n", 0, -1);
    chk("x err", {8'd0, err_cnt}, 16'd1);
    send_cmd(8'h74);
    expect_msg("t", "?\r\n", 0, -1);
    chk("t err", {8'd0, err_cnt}, 16'd2);
    send_cmd(8'h0D);
    chk("CR valid", {15'd0, tx_valid}, 16'd0);
    chk("CR err", {8'd0, err_cnt}, 16'd2);
    send_cmd(8'h0A);
    chk("LF valid", {15'd0, tx_valid}, 16'd0);
    chk("LF err", {8'd0, err_cnt}, 16'd2);

    rx_data = 8'h78;
    rx_valid = 1;
    for (int k = 0; k < 300; k++) tick();
    rx_valid = 0;
    chk("saturate err", {8'd0, err_cnt}, 16'h00FF);
    for (int k = 0; k < 10 && busy; k++) tick();
    chk("saturate drained", {15'd0, busy}, 16'd0);
    chk("saturate hold", {8'd0, err_cnt}, 16'h00FF);

    do_reset();
    hour_bcd = 8'h2A;
    send_cmd(8'h54);
    expect_msg("bad hour", "2?:29:05\r\n", 0, -1);
    hour_bcd = 8'h21;

    send_cmd(8'h41);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("abort data[%0d]", i), {8'd0, tx_data}, {8'd0, 8'h32 - 8'(i == 1 ? 2 : i == 3 ? 8'hFE : 0)});
      tick();
    end
    reset_n = 0;
    tick();
    chk("abort valid", {15'd0, tx_valid}, 16'd0);
    chk("abort busy", {15'd0, busy}, 16'd0);
    chk("abort data", {8'd0, tx_data}, 16'h0000);
    reset_n = 1;
    tick();
    chk("abort idle", {15'd0, tx_valid}, 16'd0);
    send_cmd(8'h41);
    expect_msg("A restart", "2024-09-11 21:29:05\r\n", 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/time_query_responder.md
TIME_QUERY_RESPONDER -- requirements
Module: time_query_responder

Interface
REQ-001 SHALL have parameter CMD_TIME, default 8'h54 ('T'), command byte that requests "hh:mm:ss\r\n" (10 bytes).
REQ-002 SHALL have parameter CMD_DATE, default 8'h44 ('D'), command byte that requests "YYYY-MM-DD\r\n" (12 bytes).
REQ-003 SHALL have parameter CMD_ALL, default 8'h41 ('A'), command byte that requests "YYYY-MM-DD hh:mm:ss\r\n" (21 bytes).
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port reset_n, input, 1, reset, synchronous, active-low.
REQ-006 SHALL have port rx_data, input, 8, received command byte.
REQ-007 SHALL have port rx_valid, input, 1, one-cycle strobe qualifying rx_data.
REQ-008 SHALL have ports year_bcd (input, 16), month_bcd (input, 8), day_bcd (input, 8), hour_bcd (input, 8), minute_bcd (input, 8) and second_bcd (input, 8), live BCD calendar time.
REQ-009 SHALL have port tx_data, output, 8, response byte to the UART serialiser.
REQ-010 SHALL have port tx_valid, output, 1, qualifies tx_data.
REQ-011 SHALL have port tx_ready, input, 1, serialiser accepts the byte when tx_valid && tx_ready.
REQ-012 SHALL have port busy, output, 1, response in progress.
REQ-013 SHALL have port err_cnt, output, 8, count of unknown and dropped commands, saturating.

Function
REQ-014 SHALL implement states IDLE and SEND; busy SHALL equal (state==SEND).
REQ-015 In IDLE, rx_valid with a known command SHALL latch all six BCD inputs into a snapshot, select the message, clear the byte index to 0 and enter SEND on the next edge.
REQ-016 In IDLE, rx_valid with 8'h0D or 8'h0A SHALL be ignored, with no response and no err_cnt change.
REQ-017 In IDLE, rx_valid with any other byte SHALL send "?\r\n" (3 bytes) and increment err_cnt.
REQ-018 In SEND, tx_valid SHALL be 1 and tx_data SHALL be the message byte at the current index; first tx_valid SHALL appear exactly 1 cycle after the accepted rx_valid.
REQ-019 tx_data SHALL stay stable while tx_valid && !tx_ready; the index SHALL advance only on handshake.
REQ-020 A handshake on the last byte SHALL return the block to IDLE on the same edge; tx_valid and busy SHALL be 0 in the following cycle.
REQ-021 Each digit SHALL be 8'h30 + BCD nibble; a nibble greater than 9 SHALL render as 8'h3F ('?').
REQ-022 Separators SHALL be '-' (8'h2D) in the date, ':' (8'h3A) in the time and ' ' (8'h20) between date and time in CMD_ALL; every message SHALL end with 8'h0D, 8'h0A.
REQ-023 The response SHALL use only the snapshot; input changes during SEND (e.g. seconds rollover) SHALL NOT alter the bytes sent.
REQ-024 rx_valid during SEND, including in the last-handshake cycle, SHALL be dropped and SHALL increment err_cnt unless the byte is 8'h0D or 8'h0A.
REQ-025 err_cnt SHALL saturate at 8'hFF and never wrap.
REQ-026 Commands SHALL be case-sensitive; 't' (8'h74) is an unknown command.

Reset
REQ-027 When reset_n=0 at a clk edge: state=IDLE, index=0, snapshot=0, tx_valid=0, tx_data=8'h00, busy=0, err_cnt=0.
REQ-028 Reset asserted mid-message SHALL abort it immediately; no further bytes SHALL be sent, and the next command after release SHALL restart from byte 0.

Structure
REQ-029 A shared package SHALL hold the ASCII constants (digit base, '-', ':', ' ', '?', CR, LF), the default command codes and the message lengths 10, 12, 21 and 3.
REQ-030 One combinational sub-module, time_char_mux, SHALL map (message type, index, snapshot) to a byte; the FSM, index counter and err_cnt SHALL live in the top module.
REQ-031 Index width SHALL be 5 bits.

Verification
REQ-032 Snapshot 2024-09-11 21:29:05, rx 'T', tx_ready=1 -> bytes 32 31 3A 32 39 3A 30 35 0D 0A, busy for exactly 10 cycles.
REQ-033 'A' with tx_ready toggling 1/0 -> "2024-09-11 21:29:05\r\n" (21 bytes), tx_data stable through every stall, no byte lost or repeated.
REQ-034 'D' sent, then second_bcd/day_bcd changed during SEND and a second 'T' injected mid-message -> "2024-09-11\r\n" unchanged, second 'T' dropped, err_cnt=1.
REQ-035 rx 'x' -> "?\r\n", err_cnt=1; rx 0x0D -> nothing sent, err_cnt=1; 300 unknown bytes -> err_cnt=8'hFF.
REQ-036 hour_bcd=8'h2A with 'T' -> first bytes 32 3F; reset pulsed after 4 bytes of 'A' -> tx_valid=0 the next cycle, and a following 'A' starts at '2'.
